ctrl_store_loader: RTL and testbench
====================================

Name: ctrl_store_loader

Overview:
- Writer side of the microcode control store that the sequencer reads at address {opcode, stage}.
- Accepts a byte stream from the chip-level programming interface over a valid/ready handshake.
- Decodes a small command protocol, assembles 35-bit control words from 5 bytes each, and issues single-cycle writes into the control store RAM.
- Holds the CPU (cpu_hold) until an END command has been accepted.

Parameters:
- WORD_W, 35, control word width (bits 34..0; bit 34 = END-of-instruction).
- ADDR_W, 12, control store address width ({opcode[7:0], stage[3:0]}).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
- wr_en  out  1  control store write strobe, one cycle per word.
- wr_addr  out  ADDR_W  control store write address.
- wr_data  out  WORD_W  control store write data.
- cpu_hold  out  1  high until END is accepted; keeps the sequencer stage counter in reset.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset: all outputs 0 except cpu_hold=1 and in_ready=1. State=IDLE, addr=0, byte index=0, word count=0.
- Commands (first byte seen in IDLE):
  - 0xA5 SET_ADDR, then 2 bytes: hi (bits 3:0 used, bits 7:4 must be 0) and lo. Sets addr={hi[3:0],lo}.
  - 0x5A WRITE, then count byte N (0 means 256), then N×5 data bytes.
  - 0x3C END.
  - Any other byte: set err, stay in IDLE, byte consumed.
- States and transitions:
  - IDLE: on 0xA5 go to ADDR_H; on 0x5A go to COUNT; on 0x3C go to IDLE.
  - ADDR_H: if hi[7:4]!=0, set err and return to IDLE. Otherwise go to ADDR_L.
  - ADDR_L: go to IDLE.
  - COUNT: go to DATA.
  - DATA: collects 5 bytes little-endian. Byte0 gives bits 7:0; byte4 bits 2:0 give bits 34:32; byte4 bits 7:3 are ignored. After byte4 go to WRITE.
  - WRITE: one cycle. wr_en=1 with wr_addr=addr and wr_data=assembled word; in_ready=0. Then addr increments, wrapping 4095→0, and the remaining count decrements. If count reaches 0, go to IDLE; otherwise go to DATA.
  - CHK: present only with the optional feature.
- in_ready: 1 in every state except WRITE. Gaps in in_valid are allowed anywhere; state holds while no byte transfers.
- Throughput: 5 bytes, then one write cycle. Latency is exactly 1 cycle from accepting byte4 to wr_en.
- wr_en, wr_addr and wr_data are registered. wr_en is 0 in all states except WRITE. wr_addr/wr_data are don't-care when wr_en=0 and hold their last values.
- END: accepted in IDLE. cpu_hold drops to 0 on the next cycle.
  - A subsequent SET_ADDR or WRITE command byte sets cpu_hold back to 1 in the cycle after acceptance, so reprogramming always halts the CPU.
  - END while cpu_hold is already 0 has no effect.
- err: sticky until rst_n. It does not block further commands.
- Reset mid-operation: a partial word is discarded with no write, and cpu_hold returns to 1.
- Address wrap: writing across 0xFFF continues at 0x000 with no error.

Optional Feature:
- Macro: CTRL_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE cycle of a command, state goes to CHK instead of IDLE.
  - CHK accepts one byte that must equal the XOR of all N×5 data bytes of that command.
  - On mismatch, set err; already-written words remain. On match, no effect.
  - In either case, go to IDLE.
- Undefined: no CHK state; WRITE with count 0 goes directly to IDLE.

Test Plan:
- Reset, then send A5 01 23, then 5A 01, then 11 22 33 44 05 → exactly one wr_en pulse, wr_addr=0x123, wr_data=35'h5_4433_2211, one cycle after the last byte. cpu_hold=1, busy=0 afterwards.
- A5 0F FF, then 5A 02 with two words → writes to 0xFFF then 0x000 (wrap); err=0. in_ready=0 only during the 2 WRITE cycles.
- Send 3C → cpu_hold 1→0 the next cycle. Then send 5A → cpu_hold=1 the cycle after acceptance.
- Send 77, then A5 10 → err=1 after 77. The A5 10 hi-byte also flags error and returns to IDLE. A later valid WRITE still produces wr_en.
- Randomly deassert in_valid between bytes of a WRITE; pulse rst_n low after byte 3 of a word → no wr_en, cpu_hold=1, addr=0.
- With CTRL_LOADER_CHECKSUM_EN: 5A 01 01 02 04 08 00, then 0F → err=0. Repeat with checksum 0E → err=1, and the word has still been written.

Source files
------------

// File: rtl/ctrl_store_loader_if.sv
// Byte stream and control-store write bus between the programming source and the loader.
//   in_data/in_valid : stream byte from the source, with its valid flag
//   in_ready         : loader can take the byte this cycle
//   wr_en            : one-cycle control store write strobe
//   wr_addr/wr_data  : control store write address and word
// Modports: master = programming source / store side, slave = loader.
interface ctrl_store_loader_if #(
  parameter int unsigned WORD_W = 35,
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/ctrl_store_loader.sv
// Microcode control store loader: decodes a byte command stream (SET_ADDR 0xA5, WRITE 0x5A,
// END 0x3C), packs 5 bytes little-endian into 35-bit words and writes them into the store.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : stream input and control store write bus (slave modport)
//   cpu_hold   : holds the sequencer until END is accepted
//   busy       : loader is outside IDLE
//   err        : sticky protocol error
// Optional: define CTRL_LOADER_CHECKSUM_EN to require an XOR checksum byte after each WRITE.
module ctrl_store_loader #(
  parameter int unsigned WORD_W = 35,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_store_loader_if.slave   bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrH,
    StAddrL,
    StCount,
    StData,
    StWrite
`ifdef CTRL_LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        idx_q, idx_d;
  logic [8:0]        cnt_q, cnt_d;    // words left in this command, 1..256
  logic [31:0]       word_q, word_d;  // bytes 0..3 of the word being assembled
  logic [3:0]        hi_q, hi_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
`ifdef CTRL_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic              xfer;

  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (state_q != StWrite);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != StIdle);
  assign err          = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    err_d     = err_q;
`ifdef CTRL_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          case (bus.in_data)
            8'hA5: begin
              state_d = StAddrH;
              hold_d  = 1'b1;
            end
            8'h5A: begin
              state_d = StCount;
              hold_d  = 1'b1;
            end
            8'h3C:   hold_d = 1'b0;
            default: err_d  = 1'b1;
          endcase
        end
      end
      StAddrH: begin
        if (xfer) begin
          if (bus.in_data[7:4] != 4'd0) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            hi_d    = bus.in_data[3:0];
            state_d = StAddrL;
          end
        end
      end
      StAddrL: begin
        if (xfer) begin
          addr_d  = {hi_q, bus.in_data};
          state_d = StIdle;
        end
      end
      StCount: begin
        if (xfer) begin
          cnt_d   = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          idx_d   = 3'd0;
          state_d = StData;
`ifdef CTRL_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      StData: begin
        if (xfer) begin
`ifdef CTRL_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (idx_q == 3'd4) begin
            // Output registers load here so wr_en appears the cycle after byte 4.
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {bus.in_data[2:0], word_q};
            idx_d     = 3'd0;
            state_d   = StWrite;
          end else begin
            case (idx_q[1:0])
              2'd0:    word_d[7:0]   = bus.in_data;
              2'd1:    word_d[15:8]  = bus.in_data;
              2'd2:    word_d[23:16] = bus.in_data;
              default: word_d[31:24] = bus.in_data;
            endcase
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StWrite: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
`ifdef CTRL_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StIdle;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef CTRL_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          if (bus.in_data != csum_q) err_d = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      idx_q     <= 3'd0;
      cnt_q     <= 9'd0;
      word_q    <= 32'd0;
      hi_q      <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      err_q     <= 1'b0;
`ifdef CTRL_LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
`ifdef CTRL_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_store_loader.sv
// Self-checking bench for ctrl_store_loader: randomized command streams, reference model that
// interprets the byte stream command by command, and directed boundary scenarios.
module tb_ctrl_store_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold, busy, err;

  ctrl_store_loader_if #(.WORD_W(35), .ADDR_W(12)) bus ();

  ctrl_store_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit gaps = 1'b0;
  bit mon_en = 1'b0;
  logic prev_wr = 1'b0;

  logic [7:0]  sent_q[$];
  logic [46:0] obs_q[$];
  logic [46:0] exp_q[$];

  // Model state carried across commands.
  logic [11:0] m_addr = 12'd0;
  logic        m_err = 1'b0;
  logic        m_hold = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      n_vec = n_vec + 1;
      if (bus.in_ready !== ~bus.wr_en) begin
        n_err = n_err + 1;
        $display("FAIL ready_vs_write: in_ready=%b wr_en=%b, required in_ready=~wr_en",
                 bus.in_ready, bus.wr_en);
      end
      if (bus.wr_en === 1'b1 && prev_wr === 1'b1) begin
        n_err = n_err + 1;
        $display("FAIL wr_pulse: wr_en high two cycles in a row, required single cycle");
      end
      if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
      prev_wr = bus.wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL ready_timeout: in_ready stayed low 10 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sent_q.push_back(b);
  endtask

  task automatic send_write(input int nwords);
    logic [7:0] b;
    logic [7:0] cs = 8'd0;
    send_byte(8'h5A);
    send_byte((nwords == 256) ? 8'd0 : nwords[7:0]);
    for (int k = 0; k < nwords * 5; k++) begin
      b = 8'($urandom);
      cs ^= b;
      send_byte(b);
    end
`ifdef CTRL_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  // Interprets the accepted bytes as whole commands and compares the resulting writes/flags.
  task automatic check_model(input string name);
    int i = 0;
    int n;
    logic [7:0] c, hi, lo, cs;
    logic [7:0] b[5];
    while (i < sent_q.size()) begin
      c = sent_q[i];
      i++;
      if (c == 8'hA5) begin
        m_hold = 1'b1;
        hi = sent_q[i];
        i++;
        if (hi[7:4] != 4'd0) m_err = 1'b1;
        else begin
          lo = sent_q[i];
          i++;
          m_addr = {hi[3:0], lo};
        end
      end else if (c == 8'h5A) begin
        m_hold = 1'b1;
        n = (sent_q[i] == 8'd0) ? 256 : int'(sent_q[i]);
        i++;
        cs = 8'd0;
        for (int w = 0; w < n; w++) begin
          for (int k = 0; k < 5; k++) begin
            b[k] = sent_q[i];
            i++;
            cs ^= b[k];
          end
          exp_q.push_back({m_addr, b[4][2:0], b[3], b[2], b[1], b[0]});
          m_addr = m_addr + 12'd1;
        end
`ifdef CTRL_LOADER_CHECKSUM_EN
        if (sent_q[i] != cs) m_err = 1'b1;
        i++;
`endif
      end else if (c == 8'h3C) begin
        m_hold = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    n_vec = n_vec + 1;
    if (obs_q.size() !== exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL %s_count: %0d writes seen, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec = n_vec + 1;
      if (obs_q[k] !== exp_q[k]) begin
        n_err = n_err + 1;
        $display("FAIL %s_write%0d: addr/data %h/%h, required %h/%h", name, k,
                 obs_q[k][46:35], obs_q[k][34:0], exp_q[k][46:35], exp_q[k][34:0]);
      end
    end
    n_vec = n_vec + 3;
    if (err !== m_err) begin
      n_err = n_err + 1;
      $display("FAIL %s_err: err=%b, required %b", name, err, m_err);
    end
    if (cpu_hold !== m_hold) begin
      n_err = n_err + 1;
      $display("FAIL %s_hold: cpu_hold=%b, required %b", name, cpu_hold, m_hold);
    end
    if (busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL %s_busy: busy=%b, required 0", name, busy);
    end
    sent_q.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    n_vec = n_vec + 1;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, bus.in_ready, busy, err} !==
        {1'b0, 12'd0, 35'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err = n_err + 1;
      $display("FAIL reset: wr_en=%b addr=%h data=%h hold=%b ready=%b busy=%b err=%b, required 0 0 0 1 1 0 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, bus.in_ready, busy, err);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s[10] = '{8'hA5, 8'h01, 8'h23, 8'h5A, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
    gaps = 1'b0;
    foreach (s[k]) send_byte(s[k]);
    n_vec = n_vec + 1;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h123, 35'h5_4433_2211}) begin
      n_err = n_err + 1;
      $display("FAIL basic_latency: wr_en=%b addr=%h data=%h, required 1 123 544332211",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
`ifdef CTRL_LOADER_CHECKSUM_EN
    send_byte(8'h41);
`endif
    check_model("basic");
  endtask

  task automatic test_wrap();
    gaps = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'hFF);
    send_write(2);
    check_model("wrap");
  endtask

  task automatic test_end();
    gaps = 1'b0;
    send_byte(8'h3C);
    n_vec = n_vec + 1;
    if (cpu_hold !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL end_drop: cpu_hold=%b, required 0", cpu_hold);
    end
    send_byte(8'h3C);
    n_vec = n_vec + 1;
    if (cpu_hold !== 1'b0 || err !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL end_again: cpu_hold=%b err=%b, required 0 0", cpu_hold, err);
    end
    send_write(1);
    check_model("end");
    send_byte(8'h3C);
    send_byte(8'h5A);
    n_vec = n_vec + 1;
    if (cpu_hold !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL end_rehold: cpu_hold=%b, required 1", cpu_hold);
    end
    send_byte(8'h01);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
`ifdef CTRL_LOADER_CHECKSUM_EN
    send_byte(8'h01);
`endif
    check_model("rehold");
  endtask

  task automatic test_err();
    gaps = 1'b0;
    send_byte(8'h77);
    n_vec = n_vec + 1;
    if (err !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL err_badcmd: err=%b, required 1", err);
    end
    send_byte(8'hA5);
    send_byte(8'h10);
    n_vec = n_vec + 1;
    if (busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL err_badhi: busy=%b, required 0", busy);
    end
    send_write(1);
    check_model("err");
  endtask

  task automatic test_random();
    logic [7:0] c;
    gaps = 1'b1;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          send_byte(8'hA5);
          send_byte(8'($urandom_range(0, 15)));
          send_byte(8'($urandom));
        end
        2, 3, 4: send_write($urandom_range(1, 4));
        5:       send_byte(8'h3C);
        default: begin
          c = 8'($urandom);
          if (c == 8'hA5 || c == 8'h5A || c == 8'h3C) c = 8'h00;
          send_byte(c);
        end
      endcase
    end
    check_model("random");
    send_write(256);
    check_model("count256");
  endtask

  task automatic test_reset_mid();
    gaps = 1'b1;
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h5A);
    send_byte(8'h01);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (obs_q.size() != 0 || cpu_hold !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_mid: writes=%0d hold=%b err=%b busy=%b, required 0 1 0 0",
               obs_q.size(), cpu_hold, err, busy);
    end
    sent_q.delete();
    obs_q.delete();
    m_addr = 12'd0;
    m_err  = 1'b0;
    m_hold = 1'b1;
    send_write(1);
    check_model("after_reset");
  endtask

`ifdef CTRL_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] s[7] = '{8'h5A, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00};
    gaps = 1'b0;
    foreach (s[k]) send_byte(s[k]);
    send_byte(8'h0F);
    n_vec = n_vec + 1;
    if (err !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL csum_match: err=%b, required 0", err);
    end
    foreach (s[k]) send_byte(s[k]);
    send_byte(8'h0E);
    n_vec = n_vec + 1;
    if (err !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL csum_mismatch: err=%b, required 1", err);
    end
    check_model("checksum");
  endtask
`endif

  initial begin
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_wrap();
    test_end();
    test_err();
    test_random();
    test_reset_mid();
`ifdef CTRL_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
